// File: rtl/div_sched.sv
// div_sched: round-robin scheduler that lets four requesters share one
// external W-bit divider. One transaction is in flight at a time:
// grant (IDLE) -> start divider (ISSUE) -> wait for result (WAIT) ->
// hold response until accepted (RESP).
// Optional feature macro: DIV_ZERO_CHK_EN -- when defined, zero divisors are
// answered locally (quotient all ones, remainder = dividend, err=1) without
// using the divider. When undefined, rsp_err is constant 0.
module div_sched #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   req_dvnd,
  input  logic [N*W-1:0]   req_dvsr,
  output logic [N-1:0]     req_ack,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_id,
  output logic [W-1:0]     rsp_quo,
  output logic [W-1:0]     rsp_rmd,
  output logic             rsp_err,
  output logic             busy,
  output logic             div_start,
  output logic [W-1:0]     div_dvnd,
  output logic [W-1:0]     div_dvsr,
  input  logic             div_ready,
  input  logic             div_done_tick,
  input  logic [W-1:0]     div_quo,
  input  logic [W-1:0]     div_rmd
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   id_q, id_d;
  logic [W-1:0] dvnd_q, dvnd_d;
  logic [W-1:0] dvsr_q, dvsr_d;
  logic [W-1:0] quo_q, quo_d;
  logic [W-1:0] rmd_q, rmd_d;
`ifdef DIV_ZERO_CHK_EN
  logic         err_q, err_d;
`endif

  logic         rr_vld;
  logic [1:0]   rr_id;
  logic [1:0]   rr_cand;
  logic [W-1:0] sel_dvnd;
  logic [W-1:0] sel_dvsr;

  // Round-robin pick: search ptr+1, ptr+2, ptr+3, ptr; first active req wins
  always_comb begin
    rr_vld  = 1'b0;
    rr_id   = ptr_q;
    rr_cand = ptr_q;
    for (int k = 1; k <= N; k++) begin
      rr_cand = ptr_q + 2'(k);
      if (!rr_vld && req[rr_cand]) begin
        rr_vld = 1'b1;
        rr_id  = rr_cand;
      end
    end
  end

  assign sel_dvnd = req_dvnd[int'(rr_id)*W +: W];
  assign sel_dvsr = req_dvsr[int'(rr_id)*W +: W];

  // Next-state logic for the FSM and the captured transaction fields
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    dvnd_d  = dvnd_q;
    dvsr_d  = dvsr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
`ifdef DIV_ZERO_CHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (rr_vld) begin
          ptr_d  = rr_id;
          id_d   = rr_id;
          dvnd_d = sel_dvnd;
          dvsr_d = sel_dvsr;
`ifdef DIV_ZERO_CHK_EN
          if (sel_dvsr == '0) begin
            // Answer locally; the divider is never involved
            quo_d   = '1;
            rmd_d   = sel_dvnd;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        if (div_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (div_done_tick) begin
          quo_d   = div_quo;
          rmd_d   = div_rmd;
`ifdef DIV_ZERO_CHK_EN
          err_d   = 1'b0;
`endif
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset abandons any transaction, ptr=3 gives requester 0 priority
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd3;
      id_q    <= '0;
      dvnd_q  <= '0;
      dvsr_q  <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
`ifdef DIV_ZERO_CHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      dvnd_q  <= dvnd_d;
      dvsr_q  <= dvsr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
`ifdef DIV_ZERO_CHK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Outputs decoded from state; anything the current state does not drive is 0.
  // The ack is also gated by reset_n so it stays low while reset is held.
  always_comb begin
    req_ack   = '0;
    if (state_q == S_IDLE && rr_vld && reset_n) req_ack[rr_id] = 1'b1;
    busy      = (state_q != S_IDLE);
    div_start = (state_q == S_ISSUE) && div_ready;
    div_dvnd  = '0;
    div_dvsr  = '0;
    if (state_q == S_ISSUE || state_q == S_WAIT) begin
      div_dvnd = dvnd_q;
      div_dvsr = dvsr_q;
    end
    rsp_valid = (state_q == S_RESP);
    rsp_id    = '0;
    rsp_quo   = '0;
    rsp_rmd   = '0;
    rsp_err   = 1'b0;
    if (state_q == S_RESP) begin
      rsp_id  = id_q;
      rsp_quo = quo_q;
      rsp_rmd = rmd_q;
`ifdef DIV_ZERO_CHK_EN
      rsp_err = err_q;
`endif
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: a latency-3 divider model, requester drivers fed from
// per-requester vector slots, and a scoreboard monitor on the response port.
module tb_div_sched;
  localparam int W = 8;
  localparam int L = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [3:0]     req = '0;
  logic [4*W-1:0] req_dvnd = '0;
  logic [4*W-1:0] req_dvsr = '0;
  logic [3:0]     req_ack;
  logic           rsp_valid;
  logic           rsp_ready = 1'b1;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_quo, rsp_rmd;
  logic           rsp_err, busy, div_start;
  logic [W-1:0]   div_dvnd, div_dvsr;
  logic           div_ready = 1'b1;
  logic           div_done_tick = 1'b0;
  logic [W-1:0]   div_quo = '0, div_rmd = '0;

  always #5 clk = ~clk;

  div_sched #(.W(W), .N(4)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_dvnd(req_dvnd),
    .req_dvsr(req_dvsr), .req_ack(req_ack), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_quo(rsp_quo),
    .rsp_rmd(rsp_rmd), .rsp_err(rsp_err), .busy(busy),
    .div_start(div_start), .div_dvnd(div_dvnd), .div_dvsr(div_dvsr),
    .div_ready(div_ready), .div_done_tick(div_done_tick),
    .div_quo(div_quo), .div_rmd(div_rmd)
  );

  typedef struct {
    logic [1:0]   id;
    logic [W-1:0] dvnd, dvsr, quo, rmd;
    logic         err;
  } vec_t;

  vec_t       slot [4][8];
  int         cnt [4];
  int         idx [4];
  vec_t       sb[$];
  int         ack_log[$];
  int         n_vec = 0, n_miss = 0;
  int         cyc = 0, n_start = 0, n_ack = 0;
  int         ack_cyc = -1, rise_cyc = -1, bp_left = 0;
  logic       valid_prev = 1'b0;
  logic [3:0] clear_mask = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Divider model: start seen before the edge, done_tick L cycles after start
  initial begin
    logic st;
    logic [W-1:0] m_a, m_b;
    int m_cnt;
    m_cnt = 0; m_a = '0; m_b = '0;
    forever begin
      @(negedge clk);
      st = div_start;
      if (st) begin m_a = div_dvnd; m_b = div_dvsr; end
      @(posedge clk); #1;
      div_done_tick = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          div_done_tick = 1'b1;
          div_ready = 1'b1;
          div_quo = (m_b == 0) ? '1 : m_a / m_b;
          div_rmd = (m_b == 0) ? m_a : m_a % m_b;
        end
      end
      if (st) begin div_ready = 1'b0; m_cnt = L - 1; end
    end
  end

  // Scoreboard monitor: pops on every handshake, checks stability under backpressure
  initial begin
    logic hold;
    logic [1+1+2*W-1:0] held;
    vec_t e;
    hold = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (reset_n && rsp_valid) begin
        if (hold) chk("rsp_stable", {rsp_id, rsp_err, rsp_quo, rsp_rmd}, held);
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            n_vec++; n_miss++;
            $display("FAIL rsp_unexpected: got id=%0d quo=%0d, expected none", rsp_id, rsp_quo);
          end else begin
            e = sb.pop_front();
            chk("rsp_id", rsp_id, e.id);
            chk("rsp_quo", rsp_quo, e.quo);
            chk("rsp_rmd", rsp_rmd, e.rmd);
            chk("rsp_err", rsp_err, e.err);
          end
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          held = {rsp_id, rsp_err, rsp_quo, rsp_rmd};
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic add(input int id, input int a, input int b, input int q, input int r, input int e);
    slot[id][cnt[id]] = '{id: 2'(id), dvnd: W'(a), dvsr: W'(b), quo: W'(q), rmd: W'(r), err: 1'(e)};
    cnt[id]++;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; idx[i] = 0; end
    ack_log.delete();
    n_start = 0; n_ack = 0; ack_cyc = -1; rise_cyc = -1;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < 4; i++) begin
      if (idx[i] < cnt[i]) begin
        req[i] = 1'b1;
        req_dvnd[i*W +: W] = slot[i][idx[i]].dvnd;
        req_dvsr[i*W +: W] = slot[i][idx[i]].dvsr;
      end else begin
        req[i] = 1'b0;
      end
    end
  endtask

  // One clock: observe at negedge, drive just after the rising edge
  task automatic step();
    @(negedge clk);
    if (rsp_valid && !valid_prev) rise_cyc = cyc;
    valid_prev = rsp_valid;
    if (rsp_valid) chk("quiet_in_resp", {req_ack, div_start}, 0);
    if (div_start) n_start++;
    if (req_ack != 0) begin
      chk("ack_onehot", $countones(req_ack), 1);
      n_ack++;
      ack_cyc = cyc;
      for (int i = 0; i < 4; i++) begin
        if (req_ack[i]) begin
          ack_log.push_back(i);
          if (idx[i] < cnt[i]) sb.push_back(slot[i][idx[i]]);
          else begin
            n_vec++; n_miss++;
            $display("FAIL ack_idle_req: got ack for requester %0d, expected none", i);
          end
        end
      end
    end
    clear_mask = req_ack;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < 4; i++) if (clear_mask[i]) idx[i]++;
    drive_reqs();
    if (rsp_valid && bp_left > 0) begin rsp_ready = 1'b0; bp_left--; end
    else rsp_ready = 1'b1;
  endtask

  function automatic logic all_done();
    logic d;
    d = (sb.size() == 0) && !busy && !rsp_valid;
    for (int i = 0; i < 4; i++) if (idx[i] < cnt[i]) d = 1'b0;
    return d;
  endfunction

  task automatic run(input int max);
    int k;
    k = 0;
    while (!all_done() && k < max) begin step(); k++; end
    chk("run_done", all_done(), 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack"}, req_ack, 0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_id, rsp_err}, 0);
    chk({tag, "_res"}, {rsp_quo, rsp_rmd}, 0);
    chk({tag, "_div"}, {div_start, div_dvnd, div_dvsr}, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Assert reset at the current point (just after an edge) and release two edges later
  task automatic pulse_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check_zero(tag);
    sb.delete();
    valid_prev = 1'b0; clear_mask = '0; bp_left = 0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero({tag, "_hold"});
    reset_n = 1'b1;
  endtask

  initial begin
    int exp_ord [5];
    exp_ord = '{0, 1, 2, 3, 0};
    clear_all();

    // Power-on reset with every requester active: no ack may escape
    req = 4'hF; req_dvnd = {4{8'd1}}; req_dvsr = {4{8'd1}};
    @(posedge clk); #1;
    check_zero("por");
    repeat (2) @(posedge clk);
    #1;
    check_zero("por_hold");
    req = '0;
    reset_n = 1'b1;

    // Single request from requester 2: 100/7
    clear_all();
    add(2, 100, 7, 14, 2, 0);
    drive_reqs();
    run(60);
    chk("p1_acks", n_ack, 1);
    chk("p1_starts", n_start, 1);
    chk("p1_grant", (ack_log.size() > 0) ? ack_log[0] : -1, 2);
    chk("p1_latency", rise_cyc - ack_cyc, 2 + L);

    // All four requesters held from reset; requester 0 asks twice
    clear_all();
    add(0, 200, 9, 22, 2, 0);
    add(1, 50, 5, 10, 0, 0);
    add(2, 255, 16, 15, 15, 0);
    add(3, 7, 9, 0, 7, 0);
    add(0, 0, 3, 0, 0, 0);
    drive_reqs();
    pulse_reset("rst2");
    run(300);
    chk("p2_acks", ack_log.size(), 5);
    for (int k = 0; k < 5; k++)
      chk("p2_order", (k < ack_log.size()) ? ack_log[k] : -1, exp_ord[k]);
    chk("p2_starts", n_start, 5);

    // Backpressure on the first response while requester 3 waits
    clear_all();
    bp_left = 5;
    add(1, 99, 10, 9, 9, 0);
    add(3, 13, 4, 3, 1, 0);
    drive_reqs();
    run(200);
    chk("p3_bp_used", bp_left, 0);
    chk("p3_order", {(ack_log.size() > 0) ? ack_log[0] : 7, (ack_log.size() > 1) ? ack_log[1] : 7}, {32'd1, 32'd3});

    // Divide by zero from requester 2: 55/0
    clear_all();
`ifdef DIV_ZERO_CHK_EN
    add(2, 55, 0, 255, 55, 1);
`else
    add(2, 55, 0, 255, 55, 0);
`endif
    drive_reqs();
    run(60);
`ifdef DIV_ZERO_CHK_EN
    chk("p4_starts", n_start, 0);
    chk("p4_latency", rise_cyc - ack_cyc, 1);
`else
    chk("p4_starts", n_start, 1);
    chk("p4_latency", rise_cyc - ack_cyc, 2 + L);
`endif

    // Reset during WAIT, stale done_tick ignored, then requester 1 served
    clear_all();
    add(3, 77, 7, 11, 0, 0);
    drive_reqs();
    for (int k = 0; k < 20 && n_start == 0; k++) step();
    chk("p5_started", n_start, 1);
    clear_all();
    drive_reqs();
    pulse_reset("midop");
    for (int k = 0; k < 6; k++) begin
      step();
      chk("p5_idle", {busy, rsp_valid}, 0);
    end
    clear_all();
    add(1, 90, 8, 11, 2, 0);
    drive_reqs();
    run(60);
    chk("p5_grant", (ack_log.size() > 0) ? ack_log[0] : -1, 1);
    chk("p5_starts", n_start, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter W, default 8: operand/result width; shall match the shared divider's W.
REQ-002 Parameter N, fixed 4: number of requesters; requester ID width is 2.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  4  per-requester request; requester holds it and its operands until its req_ack pulse.
REQ-006 req_dvnd  input  4*W  packed dividends; requester i uses bits [i*W +: W].
REQ-007 req_dvsr  input  4*W  packed divisors, same packing.
REQ-008 req_ack  output  4  one-cycle grant/capture pulse, one-hot or zero.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  2  requester that owns the result.
REQ-012 rsp_quo, rsp_rmd  output  W each  quotient, remainder.
REQ-013 rsp_err  output  1  divide-by-zero flag.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 div_start  output  1  one-cycle start pulse to the shared divider.
REQ-016 div_dvnd, div_dvsr  output  W each  operands to the divider, stable from div_start until div_done_tick.
REQ-017 div_ready, div_done_tick  input  1 each  divider idle flag, divider completion pulse.
REQ-018 div_quo, div_rmd  input  W each  divider results, valid in the div_done_tick cycle.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: if req!=0, grant requester g by round-robin, pulse req_ack[g], capture g's operands and g, then go to ISSUE. Otherwise remain in IDLE.
REQ-021 Round-robin: search order is ptr+1, ptr+2, ptr+3, ptr (mod 4); ptr is the last granted ID and updates on each grant.
REQ-022 req is sampled only in IDLE; a req deasserted before its ack is never served.
REQ-023 ISSUE: when div_ready=1, assert div_start for exactly one cycle and go to WAIT; otherwise hold in ISSUE.
REQ-024 WAIT: on div_done_tick, register div_quo/div_rmd into rsp_quo/rsp_rmd, clear rsp_err, and go to RESP.
REQ-025 div_done_tick outside WAIT shall be ignored.
REQ-026 RESP: rsp_valid=1 while rsp_id/rsp_quo/rsp_rmd/rsp_err are held stable. When rsp_valid&rsp_ready, go to IDLE.
REQ-027 No new grant while in ISSUE, WAIT or RESP; the earliest next grant is the cycle after the response handshake.
REQ-028 Minimum latency, ack to rsp_valid: 2 cycles plus the divider latency (start to done_tick).
REQ-029 Outputs not asserted by the current state are 0.

Reset
REQ-030 On reset_n=0, immediately enter IDLE with ptr=3 (requester 0 has first priority).
REQ-031 On reset_n=0, all outputs shall be 0, including captured operands and results.
REQ-032 Reset mid-operation abandons the transaction with no response; a later div_done_tick is ignored per REQ-025.

Configuration
REQ-033 Macro DIV_ZERO_CHK_EN, when defined: a grant with a zero divisor shall bypass ISSUE/WAIT and go directly to RESP with rsp_quo = all ones, rsp_rmd = dividend, rsp_err=1. No div_start is issued.
REQ-034 Macro DIV_ZERO_CHK_EN, when not defined: zero divisors are forwarded to the divider like any other request, and rsp_err is tied to 0.

Verification
REQ-035 Single request, req=0100, dvnd=100, dvsr=7: one req_ack[2] pulse, one div_start, then rsp_id=2, quo=14, rmd=2, err=0.
REQ-036 All four requesters held from reset, each response accepted immediately: grant order 0,1,2,3,0; operands go to the divider unmixed (e.g. 200/9 gives 22 r 2).
REQ-037 Backpressure, rsp_ready low for 5 cycles in RESP: rsp_* stable throughout, no req_ack and no div_start until the handshake completes.
REQ-038 Divide by zero, dvnd=55, dvsr=0:
- with DIV_ZERO_CHK_EN: no div_start, and rsp_valid arrives 1 cycle after ack with quo=255, rmd=55, err=1;
- without DIV_ZERO_CHK_EN: div_start issued and err=0.
REQ-039 reset_n pulsed low during WAIT: outputs go to 0 at once; the stale div_done_tick is ignored; the next req=0010 is granted to requester 1 and completes normally.
